// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage, group carry registered between stages.
// Latency NG = WIDTH/GROUP clocks; a stalled output freezes every stage and drops in_ready.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0 || NG < 1) begin : g_cfg_err
        $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
    end

    // Every carry is a flat sum-of-products over the group's p/g, so nothing ripples.
    function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] p,
                                                   input logic [GROUP-1:0] g,
                                                   input logic             ci);
        logic [GROUP:0] c;
        logic           term;
        c[0] = ci;
        for (int i = 1; i <= GROUP; i++) begin
            term = ci;
            for (int j = 0; j < i; j++) term = term & p[j];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    logic stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar k = 0; k < NG; k++) begin : g_stg
        logic [WIDTH-1:0] a_in, b_in, sum_in, sum_nxt;
        logic             c_in, v_in;
        logic [WIDTH-1:0] a_q, b_q, sum_q;
        logic             c_q, v_q;
        logic [GROUP-1:0] p, g;
        logic [GROUP:0]   c;

        if (k == 0) begin : g_head
            assign a_in   = a;
            assign b_in   = sub ? ~b : b;
            assign c_in   = sub ? 1'b1 : cin;
            assign sum_in = '0;
            assign v_in   = in_valid & in_ready;
        end else begin : g_body
            assign a_in   = g_stg[k-1].a_q;
            assign b_in   = g_stg[k-1].b_q;
            assign c_in   = g_stg[k-1].c_q;
            assign sum_in = g_stg[k-1].sum_q;
            assign v_in   = g_stg[k-1].v_q;
        end

        assign p = a_in[k*GROUP +: GROUP] ^ b_in[k*GROUP +: GROUP];
        assign g = a_in[k*GROUP +: GROUP] & b_in[k*GROUP +: GROUP];
        assign c = cla_carries(p, g, c_in);

        always_comb begin
            sum_nxt = sum_in;
            sum_nxt[k*GROUP +: GROUP] = p ^ c[GROUP-1:0];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                a_q   <= '0;
                b_q   <= '0;
                sum_q <= '0;
                c_q   <= 1'b0;
                v_q   <= 1'b0;
            end else if (!stall) begin
                a_q   <= a_in;
                b_q   <= b_in;
                sum_q <= sum_nxt;
                c_q   <= c[GROUP];
                v_q   <= v_in;
            end
        end
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= g_stg[NG-1].c[GROUP] ^ g_stg[NG-1].c[GROUP-1];
        end
    end

    assign out_valid = g_stg[NG-1].v_q;
    assign sum       = g_stg[NG-1].sum_q;
    assign cout      = g_stg[NG-1].c_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder in (16,4), (32,8) and (8,8) configurations.
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar ci = 0; ci < 3; ci++) begin : g_cfg
        localparam int W  = (ci == 0) ? 16 : (ci == 1) ? 32 : 8;
        localparam int G  = (ci == 0) ? 4 : 8;
        localparam int NG = W / G;
        localparam longint MAXP = (64'sd1 <<< (W - 1)) - 64'sd1;
        localparam longint MINN = -(64'sd1 <<< (W - 1));

        logic         rst_n     = 1'b0;
        logic         in_valid  = 1'b0;
        logic         in_ready;
        logic [W-1:0] a         = '0;
        logic [W-1:0] b         = '0;
        logic         cin       = 1'b0;
        logic         sub       = 1'b0;
        logic         out_valid;
        logic         out_ready = 1'b1;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         fin       = 1'b0;

        logic [W+1:0] exp_q[$];
        logic         prev_stall = 1'b0;
        logic [W+2:0] prev_out   = '0;

        pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .sum      (sum),
            .cout     (cout),
            .ovf      (ovf)
        );

        // Behavioural reference: plain unsigned and signed integer arithmetic.
        function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic c_in, input logic s);
            longint       sx, sy, r;
            logic [W-1:0] rs;
            logic         co, ov;
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            if (s) begin
                rs = x - y;
                co = (x >= y);
                r  = sx - sy;
            end else begin
                {co, rs} = {1'b0, x} + {1'b0, y} + (W + 1)'(c_in);
                r        = sx + sy + longint'(c_in);
            end
            ov = (r > MAXP) || (r < MINN);
            return {rs, co, ov};
        endfunction

        always @(negedge clk) begin
            logic [W+1:0] e;
            if (!rst_n) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                check("in_ready", in_ready, !(out_valid && !out_ready));
                if (prev_stall) check("hold", {out_valid, sum, cout, ovf}, prev_out);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {sum, cout, ovf}, e);
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
                prev_stall = out_valid && !out_ready;
                prev_out   = {out_valid, sum, cout, ovf};
            end
        end

        task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c_in, input logic s);
            bit acc;
            int guard;
            a = x; b = y; cin = c_in; sub = s; in_valid = 1'b1;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 100) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            check("send_timeout", acc, 1);
        endtask

        task automatic single(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic c_in, input logic s);
            int cnt;
            send(x, y, c_in, s);
            in_valid = 1'b0;
            cnt = 1;
            while (!out_valid && cnt < NG + 8) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            check("latency", cnt, NG);
            repeat (2) @(posedge clk);
            #1;
        endtask

        initial begin
            int           cyc, sent;
            bit           acc;
            logic [W-1:0] ones, maxp, minn;
            ones = '1;
            maxp = ones >> 1;
            minn = ~maxp;

            repeat (2) @(posedge clk);
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_sum", sum, 0);
            check("rst_cout", cout, 0);
            check("rst_ovf", ovf, 0);
            check("rst_in_ready", in_ready, 1);
            rst_n = 1'b1;
            @(posedge clk);
            #1;

            single(ones, W'(1), 1'b0, 1'b0);
            single(maxp, W'(1), 1'b0, 1'b0);
            single(W'(16'h1234), W'(16'h0FFF), 1'b1, 1'b0);
            single(minn, W'(1), 1'b1, 1'b1);
            single(W'(3), W'(5), 1'b0, 1'b1);

            fork
                begin
                    for (int i = 0; i < 8; i++) send(W'(i), W'(i << 4), 1'b0, 1'b0);
                    in_valid = 1'b0;
                end
                begin
                    repeat (5) @(posedge clk);
                    #1;
                    out_ready = 1'b0;
                    repeat (3) @(posedge clk);
                    #1;
                    out_ready = 1'b1;
                end
            join
            repeat (NG + 3) @(posedge clk);
            #1;
            check("bp_drain", exp_q.size(), 0);

            for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            in_valid = 1'b0;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            check("rst_flush", out_valid, 0);
            single(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

            cyc = 0;
            sent = 0;
            while (sent < 10000 && cyc < 40000) begin
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom);
                sub = 1'($urandom);
                in_valid = ($urandom_range(3) != 0);
                out_ready = ($urandom_range(3) != 0);
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                if (acc) sent++;
                cyc++;
            end
            check("rand_beats", sent, 10000);
            in_valid = 1'b0;
            out_ready = 1'b1;
            repeat (NG + 3) @(posedge clk);
            #1;
            check("final_drain", exp_q.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        check("all_done", {g_cfg[0].fin, g_cfg[1].fin, g_cfg[2].fin}, 3'b111);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor: the next generation of the team's 4-bit-group CLA adders. Each pipeline stage resolves one GROUP-bit lookahead group, and the group carry is registered between stages. The result is one add or subtract per cycle at a clock rate independent of WIDTH. It sits between operand producers and consumers through a valid/ready handshake. It adds subtract mode, a signed-overflow flag and back-pressure, none of which the combinational adders provide.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group, which is one pipeline stage; NG = WIDTH/GROUP ≥ 1.

Ports:
- clk, input, 1, the single clock; all state updates on its rising edge.
- rst_n, input, 1, reset; synchronous and active-low.
- in_valid, input, 1, operand beat present.
- in_ready, output, 1, block can accept a beat this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry-in; used only when sub=0.
- sub, input, 1, 0 selects a+b+cin; 1 selects a−b, computed as a+~b+1.
- out_valid, output, 1, result beat present.
- out_ready, input, 1, consumer accepts the result.
- sum, output, WIDTH, result.
- cout, output, 1, carry out of the MSB; for sub, 1 means no borrow.
- ovf, output, 1, two's-complement signed overflow.

## Operation
- Per group: p = a^b', g = a&b', where b' = sub ? ~b : b.
- Group internal carries and the group carry-out use full lookahead equations inside the group. There is no ripple inside a group.
- Effective carry-in: c0 = sub ? 1 : cin.
- Stage k (0..NG−1) registers:
  - the sum bits of group k;
  - the carry out of group k;
  - the delayed operand slices of groups k+1..NG−1 (skew registers);
  - the already-computed lower sum bits (deskew registers);
  - a valid bit.
- Stage k uses the registered carry from stage k−1; stage 0 uses c0.
- ovf = carry into MSB XOR carry out of MSB. It is computed in the final stage.
- Arithmetic is modulo 2^WIDTH; cout carries the extra bit.
- Handshake and stall:
  - Global stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - A beat is accepted when in_valid & in_ready.
  - When stall=1, every pipeline register (data and valid) holds.
  - When stall=0, all stages advance. Stage 0 loads in_valid & in_ready as its valid bit.
  - Bubbles (valid=0) advance like data. Outputs are not required to compress bubbles.
- Results leave in acceptance order; none is dropped or duplicated.
- Invalid stages may hold arbitrary data; sum/cout/ovf are don't-care while out_valid=0.
- NG=1 is legal: a single registered stage.
- WIDTH not a multiple of GROUP is a configuration error; an elaboration-time check must fire.

## Timing
- Reset (rst_n=0 at a rising edge):
  - all stage valid bits clear, so out_valid=0;
  - sum, cout and ovf = 0;
  - in_ready=1 from the first cycle after reset, since out_valid=0.
- Reset mid-operation discards every in-flight beat. No result from before the reset ever appears.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NG−1 (NG register stages). For 16/4 this is 4 clocks.
- Throughput: one beat per cycle while out_ready=1.
- Stall: if out_valid=1 and out_ready=0, the output is held stable, in_ready=0, and no beat is accepted.
- Simultaneous in_valid and stall-release: when out_ready rises, in_ready rises in the same cycle and a waiting in_valid beat is accepted on that edge.
- in_ready depends combinationally on out_ready. This is the only input-to-output combinational path.

## Test plan
- Carry chain across all groups, WIDTH=16, GROUP=4: a=0xFFFF, b=0x0001, cin=0, sub=0 → sum=0x0000, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
- Signed overflow on add: 0x7FFF+0x0001, cin=0 → 0x8000, cout=0, ovf=1. With cin: 0x1234+0x0FFF, cin=1 → 0x2234, cout=0, ovf=0.
- Subtract, cin ignored: 0x8000−0x0001, cin=1 → 0x7FFF, cout=1, ovf=1. 0x0003−0x0005 → 0xFFFE, cout=0, ovf=0.
- Back-pressure: stream 8 beats back-to-back with a=i, b=i<<4, out_ready low for 3 cycles mid-stream → all 8 results i+(i<<4) in order, in_ready=0 exactly while stalled, no loss or duplication.
- Reset mid-stream: 3 beats in flight, rst_n=0 for 1 cycle → out_valid=0 the next cycle. No pre-reset result appears; the first post-reset beat emerges 4 cycles after acceptance.
- Randomised comparison against a behavioural a±b model with random in_valid/out_ready, 10k beats, for (16,4), (32,8) and (8,8) (NG=1, latency 1).
